// File: rtl/fifo_rd_packer.sv
// Pops words from a first-word-fall-through FIFO and packs RATIO of them into one
// wide beat. The first popped word goes in lane 0. A flush emits a partial beat.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic                     rempty,
    input  logic [DSIZE-1:0]         rdata,
    output logic                     rinc,
    input  logic                     flush,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DSIZE*RATIO-1:0]   m_data,
    output logic [RATIO-1:0]         m_keep,
    output logic                     busy
);

    localparam int IW = $clog2(RATIO);
    localparam int AW = DSIZE * (RATIO - 1);
    localparam logic [IW-1:0] LAST = IW'(RATIO - 1);

    logic [AW-1:0]          acc_reg, acc_next;
    logic [IW-1:0]          idx_reg, idx_next;
    logic                   flush_pend_reg, flush_pend_next;
    logic                   m_valid_reg, m_valid_next;
    logic [DSIZE*RATIO-1:0] m_data_reg, m_data_next;
    logic [RATIO-1:0]       m_keep_reg, m_keep_next;

    logic                   out_free;
    logic                   flush_emit;
    logic                   pop;
    logic [DSIZE*RATIO-1:0] flush_data;
    logic [RATIO-1:0]       flush_keep;

    assign out_free   = !m_valid_reg || m_ready;
    assign flush_emit = flush_pend_reg && (idx_reg != '0) && out_free;
    // The last lane can only be popped when the output register can take the beat.
    assign pop        = rrst_n && !rempty && !flush_emit && ((idx_reg != LAST) || out_free);

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign flush_keep[gi] = (IW'(gi) < idx_reg);
            if (gi < RATIO - 1) begin : g_acc
                assign acc_next[gi*DSIZE +: DSIZE] =
                    (pop && (idx_reg == IW'(gi))) ? rdata : acc_reg[gi*DSIZE +: DSIZE];
                assign flush_data[gi*DSIZE +: DSIZE] =
                    flush_keep[gi] ? acc_reg[gi*DSIZE +: DSIZE] : '0;
            end else begin : g_top
                assign flush_data[gi*DSIZE +: DSIZE] = '0;
            end
        end
    endgenerate

    always_comb begin
        idx_next        = idx_reg;
        flush_pend_next = flush_pend_reg;
        m_valid_next    = m_valid_reg;
        m_data_next     = m_data_reg;
        m_keep_next     = m_keep_reg;

        if (m_valid_reg && m_ready)
            m_valid_next = 1'b0;

        if (flush_pend_reg && ((idx_reg == '0) || flush_emit))
            flush_pend_next = 1'b0;
        if (flush)
            flush_pend_next = 1'b1;

        if (flush_emit) begin
            m_data_next  = flush_data;
            m_keep_next  = flush_keep;
            m_valid_next = 1'b1;
            idx_next     = '0;
        end else if (pop) begin
            if (idx_reg == LAST) begin
                m_data_next  = {rdata, acc_reg};
                m_keep_next  = '1;
                m_valid_next = 1'b1;
                idx_next     = '0;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            acc_reg        <= '0;
            idx_reg        <= '0;
            flush_pend_reg <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_keep_reg     <= '0;
        end else begin
            acc_reg        <= acc_next;
            idx_reg        <= idx_next;
            flush_pend_reg <= flush_pend_next;
            m_valid_reg    <= m_valid_next;
            m_data_reg     <= m_data_next;
            m_keep_reg     <= m_keep_next;
        end
    end

    assign rinc    = pop;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_keep  = m_keep_reg;
    assign busy    = (idx_reg != '0) || m_valid_reg || flush_pend_reg;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DSIZE=8, RATIO=4) with a small FWFT FIFO model
// feeding it and a monitor logging pops and accepted beats.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        busy;

    fifo_rd_packer #(.DSIZE(8), .RATIO(4)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .busy    (busy)
    );

    always #5 rclk = ~rclk;

    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr % 64];

    int          cyc = 0;
    int          pop_cnt = 0;
    int          beat_cnt = 0;
    int          vcnt = 0;
    int          pop_cyc [0:63];
    int          beat_cyc [0:31];
    logic [31:0] beat_data [0:31];
    logic [3:0]  beat_keep [0:31];

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc) begin
            rd_ptr           <= rd_ptr + 1;
            pop_cyc[pop_cnt] <= cyc;
            pop_cnt          <= pop_cnt + 1;
        end
        if (m_valid && m_ready) begin
            beat_data[beat_cnt] <= m_data;
            beat_keep[beat_cnt] <= m_keep;
            beat_cyc[beat_cnt]  <= cyc;
            beat_cnt            <= beat_cnt + 1;
        end
        if (m_valid)
            vcnt <= vcnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("  ok %s = 0x%0h", tag, got);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    int b0, p0, v0;

    initial begin
        rrst_n  = 1'b0;
        m_ready = 1'b1;
        flush   = 1'b0;

        // Reset state, with words already waiting upstream
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick(3);
        check("reset_valid", m_valid, 0);
        check("reset_data", m_data, 0);
        check("reset_keep", m_keep, 0);
        check("reset_busy", busy, 0);
        check("reset_rinc", rinc, 0);

        // Single full beat
        b0 = beat_cnt; v0 = vcnt;
        rrst_n = 1'b1;
        tick(10);
        check("t1_beats", beat_cnt - b0, 1);
        check("t1_data", beat_data[b0], 32'h44332211);
        check("t1_keep", beat_keep[b0], 4'hF);
        check("t1_valid_cycles", vcnt - v0, 1);

        // Continuous supply, back-to-back beats
        b0 = beat_cnt; p0 = pop_cnt;
        for (int i = 0; i < 16; i++) push(8'(i));
        tick(24);
        check("t2_beats", beat_cnt - b0, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_data%0d", k), beat_data[b0 + k], 32'h03020100 + 32'(k) * 32'h04040404);
            check($sformatf("t2_keep%0d", k), beat_keep[b0 + k], 4'hF);
            if (k > 0)
                check($sformatf("t2_gap%0d", k), beat_cyc[b0 + k] - beat_cyc[b0 + k - 1], 4);
        end
        check("t2_pops", pop_cnt - p0, 16);
        check("t2_pop_span", pop_cyc[p0 + 15] - pop_cyc[p0], 15);

        // Partial beat via flush
        b0 = beat_cnt;
        push(8'hA1); push(8'hA2);
        tick(4);
        check("t3_busy_partial", busy, 1);
        check("t3_no_early_beat", beat_cnt - b0, 0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(4);
        check("t3_beats", beat_cnt - b0, 1);
        check("t3_data", beat_data[b0], 32'h0000A2A1);
        check("t3_keep", beat_keep[b0], 4'h3);
        check("t3_busy_after", busy, 0);
        b0 = beat_cnt;
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        tick(8);
        check("t3_next_data", beat_data[b0], 32'hB4B3B2B1);
        check("t3_next_keep", beat_keep[b0], 4'hF);

        // Backpressure
        m_ready = 1'b0;
        b0 = beat_cnt;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        tick(8);
        check("t4_valid", m_valid, 1);
        check("t4_data", m_data, 32'hC4C3C2C1);
        p0 = pop_cnt;
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        tick(10);
        check("t4_pops_held", pop_cnt - p0, 3);
        check("t4_rinc_held", rinc, 0);
        check("t4_data_held", m_data, 32'hC4C3C2C1);
        check("t4_keep_held", m_keep, 4'hF);
        check("t4_no_beat", beat_cnt - b0, 0);
        m_ready = 1'b1;
        tick(8);
        check("t4_beats", beat_cnt - b0, 2);
        check("t4_beat0", beat_data[b0], 32'hC4C3C2C1);
        check("t4_beat1", beat_data[b0 + 1], 32'hD4D3D2D1);
        check("t4_pops", pop_cnt - p0, 4);
        check("t4_valid_low", m_valid, 0);

        // Flush while idle produces nothing
        b0 = beat_cnt;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t5_busy_pend", busy, 1);
        tick(1);
        check("t5_busy_clear", busy, 0);
        check("t5_valid", m_valid, 0);
        tick(4);
        check("t5_no_beat", beat_cnt - b0, 0);

        // Reset mid-beat discards partial words
        b0 = beat_cnt; p0 = pop_cnt;
        push(8'hE1); push(8'hE2);
        tick(4);
        check("t6_pops", pop_cnt - p0, 2);
        check("t6_busy", busy, 1);
        #2;
        rrst_n = 1'b0;
        push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
        #1;
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_data", m_data, 0);
        check("t6_rst_keep", m_keep, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_rinc", rinc, 0);
        tick(2);
        rrst_n = 1'b1;
        tick(10);
        check("t6_beats", beat_cnt - b0, 1);
        check("t6_data", beat_data[b0], 32'hF4F3F2F1);
        check("t6_keep", beat_keep[b0], 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter DSIZE, default 8, width of one FIFO word.
REQ-002 Parameter RATIO, default 4, FIFO words packed per output beat; legal range 2..16.
REQ-003 rclk  input  1  sole clock; all state updates on rising edge.
REQ-004 rrst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rempty  input  1  upstream FIFO empty flag; rdata valid whenever rempty=0 (first-word fall-through).
REQ-006 rdata  input  DSIZE  upstream FIFO head word.
REQ-007 rinc  output  1  pop strobe to upstream FIFO; one word consumed per rising edge with rinc=1.
REQ-008 flush  input  1  single-cycle request to emit any partially packed beat.
REQ-009 m_valid  output  1  output beat valid.
REQ-010 m_ready  input  1  downstream accepts beat when m_valid=1 and m_ready=1.
REQ-011 m_data  output  DSIZE*RATIO  packed beat; lane i = bits [i*DSIZE +: DSIZE].
REQ-012 m_keep  output  RATIO  per-lane valid mask for m_data.
REQ-013 busy  output  1  = (idx!=0) OR m_valid OR flush_pend; combinational.

Function
REQ-014 Internal state SHALL be: lane accumulator acc (RATIO-1 lanes), lane index idx (0..RATIO-1), flush_pend flag, registered output m_valid/m_data/m_keep.
REQ-015 out_free SHALL equal (NOT m_valid) OR m_ready.
REQ-016 flush=1 SHALL set flush_pend; flush_pend SHALL clear when a partial beat is emitted or when observed with idx=0.
REQ-017 Flush emit condition: flush_pend=1 AND idx!=0 AND out_free; flush emit SHALL take priority over popping.
REQ-018 rinc SHALL be 1 iff rempty=0 AND no flush emit this cycle AND (idx!=RATIO-1 OR out_free); rinc SHALL never be 1 while rempty=1.
REQ-019 Pop with idx<RATIO-1: acc lane idx <= rdata, idx <= idx+1, outputs unchanged except m_valid cleared if accepted.
REQ-020 Pop with idx=RATIO-1: m_data <= {rdata, acc lanes RATIO-2..0}, m_keep <= all ones, m_valid <= 1, idx <= 0, same edge.
REQ-021 Flush emit: m_data <= acc lanes 0..idx-1 with unused lanes zero, m_keep <= (1<<idx)-1, m_valid <= 1, idx <= 0, flush_pend <= 0.
REQ-022 First-popped word SHALL occupy lane 0 (LSBs); order preserved strictly.
REQ-023 m_valid SHALL fall after an accepting handshake unless a new beat loads on the same edge; m_data/m_keep SHALL be stable while m_valid=1 and m_ready=0.
REQ-024 Latency: final lane popped at edge k SHALL appear with m_valid=1 after edge k; with m_ready held 1 and rempty held 0, throughput SHALL be one beat per RATIO cycles, no bubbles.
REQ-025 Backpressure: with m_valid=1, m_ready=0, idx=RATIO-1, rinc SHALL be 0; words for lanes 0..RATIO-2 may still be popped.
REQ-026 flush with idx=0 and m_valid=0 SHALL produce no beat.

Reset
REQ-027 rrst_n=0 SHALL asynchronously force m_valid=0, m_data=0, m_keep=0, idx=0, flush_pend=0, acc=0; rinc SHALL be 0 during reset.
REQ-028 Reset asserted mid-beat SHALL discard partially packed words; first beat after release SHALL start at lane 0.

Verification (DSIZE=8, RATIO=4)
REQ-029 FIFO supplies 0x11,0x22,0x33,0x44, m_ready=1 -> one beat m_data=0x44332211, m_keep=0xF, m_valid for exactly one cycle after 4th pop.
REQ-030 Continuous supply of 0x00..0x0F, m_ready=1 -> four beats 0x03020100..0x0F0E0D0C, back-to-back every 4 cycles, rinc=1 every cycle.
REQ-031 0xA1,0xA2 popped then flush pulse -> beat m_data=0x0000A2A1, m_keep=0x3; next word lands in lane 0.
REQ-032 m_ready=0 with beat pending, 4 further words available -> exactly 3 popped, rinc=0 on 4th until handshake, m_data unchanged.
REQ-033 Flush pulse with idx=0 and m_valid=0 -> no beat, flush_pend clears next cycle, busy=0.
REQ-034 rrst_n pulsed low after 2 pops -> all outputs 0 immediately; next 4 words form full beat starting lane 0.
